acc_rsp_endpoint: RTL



---
 rtl/acc_pkg.sv | 29 ++
 rtl/acc_rsp_alu.sv | 56 +++++
 rtl/fifo_v3.sv | 64 ++++++
 rtl/acc_rsp_endpoint.sv | 133 +++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the acc_c offload channel.
// The request FIFO element carries instr, operands and tag together.
package acc_pkg;

  localparam int unsigned NumRs         = 3;
  localparam int unsigned NumWb         = 1;
  localparam int unsigned OpHartIdWidth = 5;

  localparam logic [6:0] OpcodeCustom0 = 7'b0001011;

  typedef enum logic [2:0] {
    F3Add3 = 3'b000,
    F3Mac  = 3'b001,
    F3Swap = 3'b010
  } acc_funct3_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } acc_ep_state_e;

  typedef struct packed {
    logic [31:0]                instr;
    logic [NumRs-1:0][31:0]     rs;
    logic [OpHartIdWidth-1:0]   hart_id;
  } acc_op_t;

endpackage

// File: rtl/acc_rsp_alu.sv
// Combinational decode and compute for one offloaded custom-0 op.
// mul_lat selects the long MAC latency; every other op, including errors, is single-cycle.
module acc_rsp_alu
  import acc_pkg::*;
#(
  parameter int unsigned NumWb = acc_pkg::NumWb
) (
  input  acc_op_t              op,
  output logic [NumWb*32-1:0]  data,
  output logic                 dualwb,
  output logic                 error,
  output logic                 mul_lat
);

  logic [31:0] rs1, rs2, rs3, mac;

  assign rs1 = op.rs[0];
  assign rs2 = op.rs[1];

  if (acc_pkg::NumRs > 2) begin : g_rs3
    assign rs3 = op.rs[2];
  end else begin : g_no_rs3
    assign rs3 = '0;
  end

  assign mac = rs1 * rs2 + rs3;

  always_comb begin
    data    = '0;
    dualwb  = 1'b0;
    error   = 1'b0;
    mul_lat = 1'b0;
    if (op.instr[6:0] != OpcodeCustom0) begin
      error = 1'b1;
    end else begin
      case (acc_funct3_e'(op.instr[14:12]))
        F3Add3: data[31:0] = rs1 + rs2 + rs3;
        F3Mac: begin
          data[31:0] = mac;
          mul_lat    = 1'b1;
        end
        F3Swap: begin
          if (NumWb == 2) begin
            data[31:0]              = rs2;
            data[NumWb*32-1 -: 32]  = rs1;
            dualwb                  = 1'b1;
          end else begin
            error = 1'b1;
          end
        end
        default: error = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fifo_v3.sv
// Common-cells style synchronous FIFO with optional fall-through.
// Push when full and pop when empty are ignored.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  logic [ADDR_DEPTH-1:0] rd_ptr, wr_ptr;
  logic [ADDR_DEPTH:0]   count;
  dtype                  mem [DEPTH];
  logic                  bypass, do_write, do_read;

  assign full_o   = (count == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o  = (count == '0) && !(FALL_THROUGH && push_i);
  assign usage_o  = count[ADDR_DEPTH-1:0];
  assign data_o   = (FALL_THROUGH && count == '0) ? data_i : mem[rd_ptr];

  // In fall-through mode an empty FIFO hands the word straight through without storing it.
  assign bypass   = FALL_THROUGH && (count == '0) && push_i && pop_i;
  assign do_write = push_i && !full_o && !bypass;
  assign do_read  = pop_i && !empty_o && !bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= data_i;
        wr_ptr <= (wr_ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_DEPTH'(1);
      end
      if (do_read) begin
        rd_ptr <= (rd_ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr + ADDR_DEPTH'(1);
      end
      if (do_write && !do_read) begin
        count <= count + (ADDR_DEPTH+1)'(1);
      end else if (!do_write && do_read) begin
        count <= count - (ADDR_DEPTH+1)'(1);
      end
    end
  end

endmodule

// File: rtl/acc_rsp_endpoint.sv
// Accelerator-side responder: buffers requests, runs ADD3/MAC/SWAP, returns in-order responses.
// All response outputs come straight from registers and hold while stalled.
module acc_rsp_endpoint
  import acc_pkg::*;
#(
  parameter int unsigned NumRs       = acc_pkg::NumRs,
  parameter int unsigned NumWb       = acc_pkg::NumWb,
  parameter int unsigned HartIdWidth = 5,
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned MulLatency  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    q_valid_i,
  output logic                    q_ready_o,
  input  logic [31:0]             q_instr_data_i,
  input  logic [NumRs*32-1:0]     q_rs_i,
  input  logic [HartIdWidth-1:0]  q_hart_id_i,
  output logic                    p_valid_o,
  input  logic                    p_ready_i,
  output logic [NumWb*32-1:0]     p_data_o,
  output logic [4:0]              p_rd_o,
  output logic [HartIdWidth-1:0]  p_hart_id_o,
  output logic                    p_dualwb_o,
  output logic                    p_error_o
);

  localparam int unsigned CntW = (MulLatency > 1) ? $clog2(MulLatency) : 1;

  acc_op_t       fifo_in, fifo_out;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  acc_ep_state_e state;
  logic [CntW-1:0] cnt;

  logic [NumWb*32-1:0]    alu_data;
  logic                   alu_dualwb, alu_error, alu_mul_lat;

  logic [NumWb*32-1:0]    st_data;
  logic                   st_dualwb, st_error;
  logic [4:0]             st_rd;
  logic [HartIdWidth-1:0] st_hart_id;

  assign fifo_in.instr   = q_instr_data_i;
  assign fifo_in.rs      = q_rs_i;
  assign fifo_in.hart_id = q_hart_id_i;

  assign q_ready_o = !fifo_full;
  assign fifo_push = q_valid_i && !fifo_full;
  // A pop happens from IDLE or on the response handshake, so the next op overlaps the hand-off.
  assign fifo_pop  = !fifo_empty && ((state == StIdle) || (state == StResp && p_ready_i));

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (FifoDepth),
    .dtype        (acc_op_t)
  ) i_req_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (),
    .data_i     (fifo_in),
    .push_i     (fifo_push),
    .data_o     (fifo_out),
    .pop_i      (fifo_pop)
  );

  acc_rsp_alu #(
    .NumWb (NumWb)
  ) i_alu (
    .op      (fifo_out),
    .data    (alu_data),
    .dualwb  (alu_dualwb),
    .error   (alu_error),
    .mul_lat (alu_mul_lat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= StIdle;
      cnt         <= '0;
      st_data     <= '0;
      st_dualwb   <= 1'b0;
      st_error    <= 1'b0;
      st_rd       <= '0;
      st_hart_id  <= '0;
      p_valid_o   <= 1'b0;
      p_data_o    <= '0;
      p_rd_o      <= '0;
      p_hart_id_o <= '0;
      p_dualwb_o  <= 1'b0;
      p_error_o   <= 1'b0;
    end else begin
      // The result is computed from the FIFO head at pop and held until the latency expires.
      if (fifo_pop) begin
        cnt        <= alu_mul_lat ? CntW'(MulLatency - 1) : '0;
        st_data    <= alu_data;
        st_dualwb  <= alu_dualwb;
        st_error   <= alu_error;
        st_rd      <= fifo_out.instr[11:7];
        st_hart_id <= fifo_out.hart_id;
      end
      case (state)
        StIdle: begin
          if (fifo_pop) state <= StBusy;
        end
        StBusy: begin
          if (cnt == '0) begin
            p_valid_o   <= 1'b1;
            p_data_o    <= st_data;
            p_rd_o      <= st_rd;
            p_hart_id_o <= st_hart_id;
            p_dualwb_o  <= st_dualwb;
            p_error_o   <= st_error;
            state       <= StResp;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        StResp: begin
          if (p_ready_i) begin
            p_valid_o <= 1'b0;
            state     <= fifo_pop ? StBusy : StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
